// File: rtl/dat_mem_ctl.sv
// Single-port word memory with a request/response handshake and a
// whole-array fill sequencer. Clear and reset both run the fill.
//
// state    | meaning
// ST_CLEAR | writing FILL to every word, one address per cycle (Busy)
// ST_IDLE  | accepting read/write requests
module dat_mem_ctl #(
  parameter int unsigned    DW   = 8,
  parameter int unsigned    AW   = 8,
  parameter logic [DW-1:0]  FILL = '0
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          Clear,
  input  logic          ReqValid,
  output logic          ReqRdy,
  input  logic          ReqWe,
  input  logic [AW-1:0] ReqAdr,
  input  logic [DW-1:0] ReqData,
  output logic          RspValid,
  input  logic          RspRdy,
  output logic [DW-1:0] RspData,
  output logic          Busy
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  localparam int unsigned   DEPTH    = 1 << AW;
  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            req_rdy;
  logic            busy;
  logic            req_acc;
  logic            mem_we;
  logic [AW-1:0]   mem_adr;
  logic [DW-1:0]   mem_wdata;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        ST_IDLE:  state_d = ST_IDLE;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == ST_CLEAR);
    req_rdy = (state_q == ST_IDLE) && !Clear && (!rsp_valid_q || RspRdy);
  end

  // The Clear edge itself only restarts the counter; filling begins on the next edge.
  always_comb begin
    req_acc     = ReqValid && req_rdy;
    cnt_d       = cnt_q;
    mem_we      = 1'b0;
    mem_adr     = ReqAdr;
    mem_wdata   = ReqData;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (Clear) begin
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      cnt_d     = cnt_q + 1'b1;
      mem_we    = 1'b1;
      mem_adr   = cnt_q;
      mem_wdata = FILL;
    end else begin
      if (rsp_valid_q && RspRdy) begin
        rsp_valid_d = 1'b0;
      end
      if (req_acc) begin
        if (ReqWe) begin
          mem_we = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_q[ReqAdr];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Storage is deliberately not reset; the fill sequence initialises it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_adr] <= mem_wdata;
    end
  end

  assign ReqRdy   = req_rdy;
  assign Busy     = busy;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;

endmodule

// File: tb/tb_dat_mem_ctl.sv
// Bench for dat_mem_ctl (AW=4, DW=8, FILL=A5): reference memory plus a
// queue of expected read data, checked whenever a response is taken.
module tb_dat_mem_ctl;

  localparam int unsigned   DW   = 8;
  localparam int unsigned   AW   = 4;
  localparam logic [DW-1:0] FILL = 8'hA5;
  localparam int unsigned   DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          ResetN = 1'b0;
  logic          Clear = 1'b0;
  logic          ReqValid = 1'b0;
  logic          ReqRdy;
  logic          ReqWe = 1'b0;
  logic [AW-1:0] ReqAdr = '0;
  logic [DW-1:0] ReqData = '0;
  logic          RspValid;
  logic          RspRdy = 1'b0;
  logic [DW-1:0] RspData;
  logic          Busy;

  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  dat_mem_ctl #(.DW(DW), .AW(AW), .FILL(FILL)) dut (
    .CLK(CLK), .ResetN(ResetN), .Clear(Clear),
    .ReqValid(ReqValid), .ReqRdy(ReqRdy), .ReqWe(ReqWe),
    .ReqAdr(ReqAdr), .ReqData(ReqData),
    .RspValid(RspValid), .RspRdy(RspRdy), .RspData(RspData),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: mirrors handshakes that will occur at the next rising edge.
  always @(negedge CLK) begin
    if (!ResetN || Clear) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = FILL;
    end else begin
      if (RspValid && RspRdy) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got data %h, expected no response", RspData);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (RspData !== e) $display("FAIL rsp_data: got %h, expected %h", RspData, e);
          else n_pass++;
        end
      end
      if (ReqValid && ReqRdy) begin
        if (ReqWe) mdl_mem[ReqAdr] = ReqData;
        else exp_q.push_back(mdl_mem[ReqAdr]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Clear = 1'b0; ReqValid = 1'b0; ReqWe = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 16) $display("FAIL %s: Busy lasted %0d edges, expected 16", name, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    #12;
    n_total++;
    if ({Busy, ReqRdy, RspValid, RspData} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got busy=%b rdy=%b vld=%b data=%h, expected 1 0 0 00",
               Busy, ReqRdy, RspValid, RspData);
    else n_pass++;
    @(negedge CLK);
    ResetN = 1'b1;
    count_busy("reset_busy_len");
  endtask

  task automatic test_fill_read();
    int bad_rdy;
    bad_rdy = 0;
    RspRdy = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ReqValid = 1'b1; ReqWe = 1'b0; ReqAdr = AW'(a);
      #1;
      if (ReqRdy !== 1'b1) bad_rdy++;
      tick();
    end
    idle_inputs();
    tick();
    n_total++;
    if (bad_rdy !== 0) $display("FAIL fill_read_rdy: ReqRdy low %0d times, expected 0", bad_rdy);
    else n_pass++;
  endtask

  task automatic test_wr_rd();
    RspRdy = 1'b1;
    ReqValid = 1'b1; ReqWe = 1'b1; ReqAdr = 4'd5; ReqData = 8'h3C;
    tick();
    ReqWe = 1'b0;
    tick();
    n_total++;
    if ({RspValid, RspData} !== {1'b1, 8'h3C})
      $display("FAIL wr_rd: got vld=%b data=%h, expected 1 3c", RspValid, RspData);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int bad_rdy;
    bad_rdy = 0;
    RspRdy = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      ReqValid = 1'b1; ReqWe = 1'b1; ReqAdr = AW'(a); ReqData = 8'(8'h10 * a + a);
      tick();
    end
    ReqWe = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      ReqAdr = AW'(a);
      #1;
      if (ReqRdy !== 1'b1) bad_rdy++;
      tick();
      n_total++;
      if (RspValid !== 1'b1) $display("FAIL b2b_valid: addr %0d got vld=%b, expected 1", a, RspValid);
      else n_pass++;
    end
    idle_inputs();
    tick();
    n_total++;
    if (bad_rdy !== 0) $display("FAIL b2b_rdy: ReqRdy low %0d times, expected 0", bad_rdy);
    else n_pass++;
    n_total++;
    if (RspValid !== 1'b0) $display("FAIL b2b_drain: got vld=%b, expected 0", RspValid);
    else n_pass++;
  endtask

  task automatic test_stall();
    int bad;
    RspRdy = 1'b0;
    ReqValid = 1'b1; ReqWe = 1'b0; ReqAdr = 4'd5;
    tick();
    ReqAdr = 4'd1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ReqRdy !== 1'b0 || RspValid !== 1'b1 || RspData !== 8'h3C) bad++;
      tick();
    end
    n_total++;
    if (bad !== 0) $display("FAIL stall_hold: %0d bad cycles (rdy/vld/data), expected 0", bad);
    else n_pass++;
    ReqValid = 1'b0;
    RspRdy = 1'b1;
    tick();
    n_total++;
    if (RspValid !== 1'b0) $display("FAIL stall_release: got vld=%b, expected 0", RspValid);
    else n_pass++;
  endtask

  task automatic test_clear();
    RspRdy = 1'b0;
    ReqValid = 1'b1; ReqWe = 1'b0; ReqAdr = 4'd2;
    tick();
    Clear = 1'b1; ReqWe = 1'b1; ReqAdr = 4'd9; ReqData = 8'h77;
    #1;
    n_total++;
    if (ReqRdy !== 1'b0) $display("FAIL clear_rdy: got %b, expected 0", ReqRdy);
    else n_pass++;
    tick();
    Clear = 1'b0; ReqValid = 1'b0; ReqWe = 1'b0;
    n_total++;
    if ({RspValid, Busy} !== 2'b01)
      $display("FAIL clear_entry: got vld=%b busy=%b, expected 0 1", RspValid, Busy);
    else n_pass++;
    count_busy("clear_busy_len");
    test_fill_read();
  endtask

  task automatic test_reset_mid_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    ResetN = 1'b0;
    #1;
    n_total++;
    if ({Busy, ReqRdy, RspValid, RspData} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL midclr_reset: got busy=%b rdy=%b vld=%b data=%h, expected 1 0 0 00",
               Busy, ReqRdy, RspValid, RspData);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    ResetN = 1'b1;
    count_busy("midclr_busy_len");
    test_fill_read();
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_wr_rd();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_mid_clear();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL rsp_missing: %0d responses outstanding, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
